// File: rtl/and_or_scheduler_if.sv
// Request/result handshake bundle for the shared AND/OR reduction scheduler.
// The master side belongs to the requesters and the result consumer.
interface and_or_scheduler_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_sel;
  logic                   res_valid;
  logic                   res_ready;
  logic                   res_y;
  logic [ID_W-1:0]        res_id;

  modport master (
    output req_valid, req_data, req_sel, res_ready,
    input  req_ready, res_valid, res_y, res_id
  );

  modport slave (
    input  req_valid, req_data, req_sel, res_ready,
    output req_ready, res_valid, res_y, res_id
  );
endinterface

// File: rtl/and_or_scheduler.sv
// Round-robin scheduler sharing one chunked AND/OR reduction engine between NREQ
// requesters; the engine stops as soon as the running result can no longer change.
module and_or_scheduler #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  and_or_scheduler_if.slave   bus,
  output logic                busy
);
  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [ID_W-1:0]     ptr_p0;
  logic [ID_W-1:0]     id_p0;
  logic [DATA_W-1:0]   opnd_p0;
  logic                op_and_p0;
  logic                acc_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic                vld_p0;

  logic                gnt_found;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     cand;
  logic [DATA_W-1:0]   gnt_data;
  logic                gnt_sel;
  logic [CHUNK_W-1:0]  chunk;
  logic                acc_nxt;
  logic                decisive;
  logic                accept;

  function automatic logic reduce_chunk(input logic [CHUNK_W-1:0] c, input logic op_and);
    return op_and ? (&c) : (|c);
  endfunction

  // Round-robin search starting at ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = ID_W'((int'(ptr_p0) + j) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    gnt_sel  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        gnt_data = bus.req_data[i*DATA_W +: DATA_W];
        gnt_sel  = bus.req_sel[i];
      end
    end
  end

  assign accept = (state == IDLE) && gnt_found;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_p0 == IDX_W'(i)) chunk = opnd_p0[i*CHUNK_W +: CHUNK_W];
    end
  end

  // AND settles once it hits 0, OR once it hits 1
  assign acc_nxt  = op_and_p0 ? (acc_p0 & reduce_chunk(chunk, 1'b1))
                              : (acc_p0 | reduce_chunk(chunk, 1'b0));
  assign decisive = (acc_nxt != op_and_p0);

  // Operand capture on the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      opnd_p0   <= gnt_data;
      op_and_p0 <= gnt_sel;
    end
  end

  // Control FSM: IDLE -> RUN -> DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr_p0 <= '0;
      id_p0  <= '0;
      acc_p0 <= 1'b0;
      idx_p0 <= '0;
      vld_p0 <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            id_p0  <= gnt_id;
            acc_p0 <= gnt_sel;
            idx_p0 <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc_p0 <= acc_nxt;
          idx_p0 <= idx_p0 + 1'b1;
          if (decisive || (idx_p0 == IDX_W'(NCHUNK-1))) begin
            vld_p0 <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            vld_p0 <= 1'b0;
            busy   <= 1'b0;
            ptr_p0 <= (id_p0 == ID_W'(NREQ-1)) ? '0 : id_p0 + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = vld_p0;
  assign bus.res_y     = acc_p0;
  assign bus.res_id    = id_p0;
endmodule

// File: tb/tb_and_or_scheduler.sv
// Scoreboard bench for and_or_scheduler: accepts push the modelled result and
// its expected res_valid cycle; result handshakes pop and compare.
module tb_and_or_scheduler;
  localparam int NREQ    = 4;
  localparam int DATA_W  = 32;
  localparam int CHUNK_W = 8;
  localparam int NCHUNK  = DATA_W / CHUNK_W;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  and_or_scheduler_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus();

  and_or_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  logic [DATA_W-1:0] opd   [NREQ];
  logic              opsel [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign bus.req_data[g*DATA_W +: DATA_W] = opd[g];
    assign bus.req_sel[g]                   = opsel[g];
  end

  typedef struct {
    logic [1:0] id;
    logic       y;
    int         t;
  } exp_t;

  exp_t sbq[$];
  int   acc_log[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   n_res = 0;
  int   rise_t = 0;
  logic prev_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [DATA_W-1:0] d, input logic s,
                                output logic y, output int k);
    logic [DATA_W-1:0] tmp;
    logic [CHUNK_W-1:0] c;
    logic a;
    logic r;
    a = s;
    k = NCHUNK - 1;
    for (int i = 0; i < NCHUNK; i++) begin
      tmp = d >> (i * CHUNK_W);
      c   = tmp[CHUNK_W-1:0];
      r   = s ? (&c) : (|c);
      a   = s ? (a & r) : (a | r);
      if (a != s) begin
        k = i;
        break;
      end
    end
    y = a;
  endfunction

  // Monitor: samples on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        prev_vld = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        check("ready_rules",
              {31'd0, $onehot0(bus.req_ready)
                      && !(busy && (bus.req_ready != '0))
                      && ((bus.req_ready & ~bus.req_valid) == '0)
                      && !(!busy && (bus.req_valid != '0) && (bus.req_ready == '0))},
              32'd1);
        if (bus.res_valid && !prev_vld) rise_t = cyc;
        prev_vld = bus.res_valid;
        if (bus.res_valid && bus.res_ready) begin
          if (sbq.size() == 0) begin
            check("spurious_result", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            check("res_y", {31'd0, bus.res_y}, {31'd0, e.y});
            check("res_id", {30'd0, bus.res_id}, {30'd0, e.id});
            check("res_latency", rise_t, e.t);
            n_res++;
          end
        end
        if ((bus.req_valid & bus.req_ready) != '0) begin
          exp_t e;
          int   k;
          logic y;
          for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i]) begin
              model(opd[i], opsel[i], y, k);
              e.id = 2'(i);
              e.y  = y;
              e.t  = cyc + k + 2;
              sbq.push_back(e);
              acc_log.push_back(i);
            end
          end
        end
      end
    end
  end

  task automatic wait_accept(input int id);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready[id]) return;
    end
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic submit(input int id, input logic [DATA_W-1:0] d, input logic s);
    @(posedge clk); #1;
    opd[id]           = d;
    opsel[id]         = s;
    bus.req_valid[id] = 1'b1;
    wait_accept(id);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (!busy && !bus.res_valid && sbq.size() == 0) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_ord [6];
    int n_before;
    exp_ord = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      opd[i]   = '0;
      opsel[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_res_y", {31'd0, bus.res_y}, 32'd0);
    check("rst_res_id", {30'd0, bus.res_id}, 32'd0);
    check("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-length AND
    busy_cnt = 0;
    submit(0, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    check("and_full_busy", busy_cnt, 5);
    check("and_full_grant", acc_log[$], 0);

    // AND decided by chunk 0
    busy_cnt = 0;
    submit(2, 32'hFFFF_FF00, 1'b1);
    wait_idle();
    check("and_early_busy", busy_cnt, 2);
    check("and_early_grant", acc_log[$], 2);

    // OR set only by the top chunk, then all-zero OR
    busy_cnt = 0;
    submit(1, 32'h0100_0000, 1'b0);
    wait_idle();
    check("or_top_busy", busy_cnt, 5);
    busy_cnt = 0;
    submit(1, 32'h0000_0000, 1'b0);
    wait_idle();
    check("or_zero_busy", busy_cnt, 5);

    // All requesters held valid from reset
    pulse_reset();
    acc_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      opd[i]   = $urandom;
      opsel[i] = 1'($urandom_range(0, 1));
    end
    bus.req_valid = 4'hF;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (acc_log.size() >= 6) break;
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle();
    check("rr_count", acc_log.size(), 6);
    for (int i = 0; i < 6 && i < acc_log.size(); i++) begin
      check($sformatf("rr_order_%0d", i), acc_log[i], exp_ord[i]);
    end

    // Consumer stalls in DONE while another requester waits
    bus.res_ready = 1'b0;
    submit(0, 32'h1234_5678, 1'b0);
    opd[3]           = 32'h0;
    opsel[3]         = 1'b1;
    bus.req_valid[3] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (bus.res_valid) break;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("hold_res_valid", {31'd0, bus.res_valid}, 32'd1);
      check("hold_res_y", {31'd0, bus.res_y}, 32'd1);
      check("hold_res_id", {30'd0, bus.res_id}, 32'd0);
      check("hold_req_ready", {28'd0, bus.req_ready}, 32'd0);
      check("hold_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check("release_busy", {31'd0, busy}, 32'd0);
    check("release_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("release_req_ready", {28'd0, bus.req_ready}, 32'h8);
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    wait_idle();

    // Reset during RUN abandons requester 3; pointer returns to 0
    submit(2, 32'h0, 1'b0);
    wait_idle();
    @(posedge clk); #1;
    opd[0]   = $urandom;
    opsel[0] = 1'b1;
    opd[3]   = 32'hFFFF_FFFF;
    opsel[3] = 1'b1;
    bus.req_valid = 4'b1001;
    wait_accept(3);
    #1;
    check("rst_run_grant", acc_log[$], 3);
    n_before = n_res;
    @(posedge clk); #1;
    pulse_reset();
    @(negedge clk); #1;
    check("rst_run_busy", {31'd0, busy}, 32'd0);
    check("rst_run_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_run_req_ready", {28'd0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle();
    check("rst_run_next_grant", acc_log[$], 0);
    check("rst_run_results", n_res, n_before + 1);
    check("sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
